// File: rtl/obstacle_spawn_sched_pkg.sv
// Package shared by the obstacle spawn scheduler and the per-obstacle move blocks.
// Holds the scheduler state type, the road geometry constants and the lane LFSR step.
package obstacle_spawn_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPick,
        StIssue,
        StWaitGap
    } sched_state_t;

    // Road geometry in screen pixels, shared with the move blocks.
    localparam int LEFT_BORDER  = 150;
    localparam int RIGHT_BORDER = 425;
    localparam int LANE_WIDTH   = 64;

    // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift towards the MSB).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/obstacle_spawn_sched_rr_arbiter.sv
// Round-robin find-first: returns the first set request bit at or after ptr_i, wrapping
// modulo NUM_SLOTS. Purely combinational.
//   req_i   : request vector
//   ptr_i   : slot index where the search starts
//   valid_o : at least one request is set
//   idx_o   : index of the granted slot (0 when valid_o is low)
module obstacle_spawn_sched_rr_arbiter #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned PtrW      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [PtrW-1:0]      ptr_i,
    output logic                 valid_o,
    output logic [PtrW-1:0]      idx_o
);

    logic [PtrW-1:0] pos;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            pos = PtrW'((32'(ptr_i) + k) % NUM_SLOTS);
            if (!valid_o && req_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/obstacle_spawn_sched.sv
// Obstacle respawn scheduler. Once per frame (when the game runs and the scheduler is idle)
// it grants one off-screen mover round-robin, picks its X lane from an LFSR and enforces a
// minimum frame gap before the next spawn.
//   clk, reset      : clock, synchronous active-high reset
//   startOfFrame    : one-cycle frame pulse
//   move_allow      : game running; low freezes gap counting and new spawns
//   restart_enable  : synchronous soft clear of everything but the LFSR
//   player_collis   : pauses the scheduler while high
//   player_speed    : player Y speed, shortens the gap when fast
//   slot_offscreen  : per mover, object is outside the visible frame
//   spawn_req       : one-hot single-cycle respawn request
//   spawn_x         : X of the granted slot, held until the next spawn
//   spawn_lane      : lane of the last spawn
//   spawn_count     : saturating spawn counter since reset/restart
module obstacle_spawn_sched #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned NUM_LANES      = 4,
    parameter int          LEFT_BORDER    = obstacle_spawn_sched_pkg::LEFT_BORDER,
    parameter int          LANE_WIDTH     = obstacle_spawn_sched_pkg::LANE_WIDTH,
    parameter int unsigned MIN_GAP_FRAMES = 20,
    parameter int unsigned FAST_SPEED     = 150,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int unsigned PtrW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned LaneW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    move_allow,
    input  logic                    restart_enable,
    input  logic                    player_collis,
    input  logic [7:0]              player_speed,
    input  logic [NUM_SLOTS-1:0]    slot_offscreen,
    output logic [NUM_SLOTS-1:0]    spawn_req,
    output logic signed [10:0]      spawn_x,
    output logic [LaneW-1:0]        spawn_lane,
    output logic [7:0]              spawn_count
);

    import obstacle_spawn_sched_pkg::*;

    sched_state_t          state_q, state_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0]  pend_q, pend_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [PtrW-1:0]       grant_q, grant_d;
    logic [LaneW-1:0]      lane_q, lane_d;
    logic [NUM_SLOTS-1:0]  spawn_req_q, spawn_req_d;
    logic signed [10:0]    spawn_x_q, spawn_x_d;
    logic [LaneW-1:0]      spawn_lane_q, spawn_lane_d;
    logic [7:0]            spawn_count_q, spawn_count_d;

    logic [NUM_SLOTS-1:0]  elig;
    logic                  frame_run;
    logic                  arb_valid;
    logic [PtrW-1:0]       arb_idx;
    logic [LaneW-1:0]      lane_raw;
    logic [LaneW-1:0]      lane_pick;

    obstacle_spawn_sched_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .PtrW      (PtrW)
    ) u_rr_arbiter (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    // A slot stays blocked after its grant until its mover has been seen on screen.
    assign elig      = slot_offscreen & ~pend_q;
    assign frame_run = startOfFrame & move_allow & ~player_collis;

    // Avoid repeating the previous lane back to back (only once a spawn has happened).
    assign lane_raw  = lfsr_q[LaneW-1:0];
    assign lane_pick = ((lane_raw == spawn_lane_q) && (spawn_count_q != 8'd0)) ?
                       lane_raw + LaneW'(1) : lane_raw;

    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        lane_d        = lane_q;
        spawn_req_d   = '0;
        spawn_x_d     = spawn_x_q;
        spawn_lane_d  = spawn_lane_q;
        spawn_count_d = spawn_count_q;
        lfsr_d        = lfsr_step(lfsr_q);
        pend_d        = pend_q & slot_offscreen;

        unique case (state_q)
            StIdle: begin
                if (frame_run && (|elig)) begin
                    state_d = StPick;
                end
            end
            StPick: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    lane_d  = lane_pick;
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                spawn_req_d  = NUM_SLOTS'(1) << grant_q;
                pend_d       = pend_d | spawn_req_d;
                spawn_x_d    = 11'(LEFT_BORDER + int'(lane_q) * LANE_WIDTH);
                spawn_lane_d = lane_q;
                rr_ptr_d     = (grant_q == PtrW'(NUM_SLOTS - 1)) ? '0 : grant_q + PtrW'(1);
                if (spawn_count_q != 8'hFF) begin
                    spawn_count_d = spawn_count_q + 8'd1;
                end
                gap_cnt_d = (player_speed >= 8'(FAST_SPEED)) ? 8'(MIN_GAP_FRAMES / 2) :
                                                               8'(MIN_GAP_FRAMES);
                state_d   = StWaitGap;
            end
            StWaitGap: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else if (frame_run) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    if (gap_cnt_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        // The LFSR only reloads on hard reset so lanes keep varying across restarts.
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end

        // Restart clears like reset, including a spawn about to be issued.
        if (reset || restart_enable) begin
            state_q       <= StIdle;
            gap_cnt_q     <= 8'd0;
            rr_ptr_q      <= '0;
            pend_q        <= '0;
            grant_q       <= '0;
            lane_q        <= '0;
            spawn_req_q   <= '0;
            spawn_x_q     <= 11'(LEFT_BORDER);
            spawn_lane_q  <= '0;
            spawn_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            pend_q        <= pend_d;
            grant_q       <= grant_d;
            lane_q        <= lane_d;
            spawn_req_q   <= spawn_req_d;
            spawn_x_q     <= spawn_x_d;
            spawn_lane_q  <= spawn_lane_d;
            spawn_count_q <= spawn_count_d;
        end
    end

    assign spawn_req   = spawn_req_q;
    assign spawn_x     = spawn_x_q;
    assign spawn_lane  = spawn_lane_q;
    assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_obstacle_spawn_sched.sv
// Self-checking bench for obstacle_spawn_sched. A frame-level model predicts each spawn
// (slot, lane, X, count and the cycle it must appear) and pushes it to a scoreboard; a
// monitor pops and compares whenever spawn_req fires.
module tb_obstacle_spawn_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        move_allow;
    logic        restart_enable;
    logic        player_collis;
    logic [7:0]  player_speed;
    logic [3:0]  slot_offscreen;
    logic [3:0]  spawn_req;
    logic signed [10:0] spawn_x;
    logic [1:0]  spawn_lane;
    logic [7:0]  spawn_count;

    obstacle_spawn_sched dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .move_allow     (move_allow),
        .restart_enable (restart_enable),
        .player_collis  (player_collis),
        .player_speed   (player_speed),
        .slot_offscreen (slot_offscreen),
        .spawn_req      (spawn_req),
        .spawn_x        (spawn_x),
        .spawn_lane     (spawn_lane),
        .spawn_count    (spawn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] req;
        int         x;
        int         lane;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_push = 0;
    logic [3:0] prev_req = 4'b0;

    // Frame-level reference state.
    logic [15:0] m_lfsr;
    bit          m_idle;
    int          m_gap, m_rr, m_last, m_cnt;
    logic [3:0]  m_pend;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_nxt(m_lfsr);
    end

    always @(negedge clk) begin
        if (!reset && spawn_req !== 4'b0) begin
            if (prev_req !== 4'b0) check_val("back_to_back", prev_req, 0);
            if (sb.size() == 0) begin
                check_val("spurious_req", spawn_req, 0);
            end else begin
                e = sb.pop_front();
                check_val("req",   spawn_req,   e.req);
                check_val("x",     spawn_x,     e.x);
                check_val("lane",  spawn_lane,  e.lane);
                check_val("count", spawn_count, e.cnt);
                check_val("cycle", cyc,         e.cyc);
            end
        end
        prev_req = spawn_req;
    end

    task automatic model_clear();
        m_idle = 1'b1;
        m_gap  = 0;
        m_rr   = 0;
        m_pend = 4'b0;
        m_last = 0;
        m_cnt  = 0;
    endtask

    // One frame: optional wait until the lane the DUT will sample equals align, then a
    // frame pulse. Entered and left on a falling edge.
    task automatic frame(input int align, input bit rst_issue, input bit bounce);
        logic [15:0] t;
        logic [15:0] pv;
        logic [3:0]  elig;
        bit          trig, run, aligned;
        int          g, ln, tcyc;
        exp_t        ne;
        if (align >= 0) begin
            aligned = 1'b0;
            for (int i = 0; i < 64 && !aligned; i++) begin
                t = lfsr_nxt(m_lfsr);
                if (int'(t[1:0]) == align) aligned = 1'b1;
                else @(negedge clk);
            end
            if (!aligned) check_val("align_timeout", 0, 1);
        end
        run  = move_allow && !player_collis;
        elig = slot_offscreen & ~m_pend;
        trig = 1'b0;
        if (m_idle) begin
            trig = run && (elig != 4'b0);
        end else if (run) begin
            m_gap--;
            if (m_gap == 0) m_idle = 1'b1;
        end
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        pv   = m_lfsr;
        tcyc = cyc;
        startOfFrame = 1'b0;
        g = 0;
        if (trig) begin
            for (int k = 3; k >= 0; k--) if (elig[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            ln = int'(pv[1:0]);
            if (ln == m_last && m_cnt != 0) ln = (ln + 1) % 4;
            if (rst_issue) begin
                @(posedge clk);
                #1 restart_enable = 1'b1;
                @(posedge clk);
                #1 restart_enable = 1'b0;
                model_clear();
            end else begin
                ne.cyc  = tcyc + 2;
                ne.req  = 4'(1 << g);
                ne.x    = 150 + 64 * ln;
                ne.lane = ln;
                ne.cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                sb.push_back(ne);
                n_push++;
                m_rr   = (g + 1) % 4;
                m_pend[g] = 1'b1;
                m_last = ln;
                m_cnt  = ne.cnt;
                m_gap  = (player_speed >= 8'd150) ? 10 : 20;
                m_idle = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        // Mover becomes visible briefly, then scrolls off again.
        if (trig && bounce && !rst_issue) begin
            slot_offscreen[g] = 1'b0;
            m_pend[g] = 1'b0;
            @(negedge clk);
            slot_offscreen[g] = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input bit bounce);
        for (int i = 0; i < 40 && !m_idle; i++) frame(-1, 1'b0, bounce);
        if (!m_idle) check_val("idle_timeout", 0, 1);
    endtask

    task automatic run_spawns(input int n, input bit bounce);
        int target;
        target = n_push + n;
        for (int i = 0; i < 400 && n_push < target; i++) frame(-1, 1'b0, bounce);
        if (n_push < target) check_val("spawn_timeout", n_push, target);
    endtask

    task automatic set_offscreen(input logic [3:0] v);
        slot_offscreen = v;
        m_pend = m_pend & v;
    endtask

    initial begin
        reset          = 1'b1;
        startOfFrame   = 1'b0;
        move_allow     = 1'b1;
        restart_enable = 1'b0;
        player_collis  = 1'b0;
        player_speed   = 8'd0;
        slot_offscreen = 4'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values.
        check_val("rst_req",   spawn_req,   0);
        check_val("rst_x",     spawn_x,     150);
        check_val("rst_lane",  spawn_lane,  0);
        check_val("rst_count", spawn_count, 0);

        // 1: slot 0 goes off-screen together with the frame pulse.
        set_offscreen(4'b0001);
        frame(-1, 1'b0, 1'b0);
        wait_idle(1'b0);

        // 2: all slots, round robin at slow then fast speed.
        restart_enable = 1'b1;
        @(negedge clk);
        restart_enable = 1'b0;
        model_clear();
        check_val("restart_count", spawn_count, 0);
        check_val("restart_x",     spawn_x,     150);
        set_offscreen(4'b1111);
        run_spawns(5, 1'b1);
        player_speed = 8'd200;
        run_spawns(3, 1'b1);
        wait_idle(1'b1);

        // 3: slot 2 held off-screen is not granted twice until it has been seen on screen.
        player_speed = 8'd0;
        set_offscreen(4'b0100);
        run_spawns(1, 1'b0);
        repeat (30) frame(-1, 1'b0, 1'b0);
        set_offscreen(4'b0000);
        @(negedge clk);
        set_offscreen(4'b0100);
        run_spawns(1, 1'b0);
        check_val("pend_regrant", spawn_req, 0);

        // 4: lane collision with the previous lane moves to the next lane.
        set_offscreen(4'b1111);
        wait_idle(1'b1);
        frame(3, 1'b0, 1'b1);
        if (m_last != 3) begin
            wait_idle(1'b1);
            frame(3, 1'b0, 1'b1);
        end
        wait_idle(1'b1);
        frame(3, 1'b0, 1'b1);
        check_val("x_hold",    spawn_x,    150 + 64 * m_last);
        check_val("lane_hold", spawn_lane, m_last);

        // 5: freeze during the gap.
        for (int i = 0; i < 20 && m_gap != 7; i++) frame(-1, 1'b0, 1'b1);
        player_collis = 1'b1;
        repeat (10) frame(-1, 1'b0, 1'b1);
        check_val("gap_hold_collis", dut.gap_cnt_q, m_gap);
        player_collis = 1'b0;
        move_allow    = 1'b0;
        repeat (2) frame(-1, 1'b0, 1'b1);
        check_val("gap_hold_move", dut.gap_cnt_q, m_gap);
        move_allow = 1'b1;
        wait_idle(1'b1);
        run_spawns(1, 1'b1);

        // 6: restart during ISSUE cancels the spawn but keeps the LFSR running.
        wait_idle(1'b1);
        frame(-1, 1'b1, 1'b0);
        check_val("rs_req",   spawn_req,   0);
        check_val("rs_count", spawn_count, 0);
        check_val("rs_x",     spawn_x,     150);
        check_val("rs_lane",  spawn_lane,  0);
        check_val("rs_lfsr",  dut.lfsr_q,  m_lfsr);
        run_spawns(1, 1'b1);

        repeat (5) @(negedge clk);
        check_val("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
